mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between instruction-cache and data-cache miss traffic in the Riscv151 core.
- Accepts one request at a time and forwards it to memory.
- Routes read-burst beats back to the owning cache; write transactions complete on request handshake.
- Sits between icache/dcache refill logic and the top-level memory interface.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, data beat width; write mask width is DATA_W/8
BEATS, 4, response beats per read burst (>=1); internal beat counter width clog2(BEATS), minimum 1

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
ic_req_valid  in  1  icache read request
ic_req_ready  out  1  icache request accepted this cycle when valid&&ready
ic_req_addr  in  ADDR_W  icache read address
ic_resp_valid  out  1  read beat for icache
ic_resp_data  out  DATA_W  read beat data
dc_req_valid  in  1  dcache request
dc_req_ready  out  1  dcache request accepted this cycle when valid&&ready
dc_req_rw  in  1  1=write, 0=read
dc_req_addr  in  ADDR_W  dcache address
dc_req_wdata  in  DATA_W  write data (single beat)
dc_req_wmask  in  DATA_W/8  byte write mask
dc_resp_valid  out  1  read beat, or one-cycle write-ack pulse, for dcache
dc_resp_data  out  DATA_W  read beat data; 0 on write ack
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_rw  out  1  latched rw
mem_req_addr  out  ADDR_W  latched address
mem_req_wdata  out  DATA_W  latched write data
mem_req_wmask  out  DATA_W/8  latched mask; 0 for reads
mem_resp_valid  in  1  read beat from memory
mem_resp_data  in  DATA_W  read beat data
busy  out  1  state != IDLE
proto_err  out  1  sticky: mem_resp_valid seen outside RESP

Behaviour:
- Reset (async assert, any state):
  - state=IDLE; owner, latched fields, beat count cleared.
  - All outputs 0; proto_err cleared.
  - An in-flight transaction is dropped; memory is reset by the same signal.
- FSM states IDLE, REQ, RESP.
- IDLE:
  - Grant is combinational from the valid inputs.
  - Fixed priority: dcache over icache.
  - Only the granted side sees ready=1; both readys are 0 outside IDLE.
  - On accept: latch owner, addr, rw, wdata, wmask (icache: rw=0, wmask=0); go to REQ.
  - Requesters hold their fields stable until accepted.
- REQ:
  - mem_req_valid=1 with latched fields; fields stay constant until mem_req_ready.
  - On handshake with rw=1: pulse dc_resp_valid for one cycle with data 0, go to IDLE.
  - On handshake with rw=0: clear beat count, go to RESP.
- RESP:
  - mem_resp_valid/mem_resp_data pass combinationally, same cycle, to the owner's resp_valid/resp_data.
  - The other side's resp_valid stays 0.
  - Each beat increments the count.
  - The beat with count==BEATS-1 returns to IDLE.
  - Gaps between beats are allowed and the arbiter waits indefinitely.
- mem_resp_valid in IDLE/REQ: ignored (not forwarded) and sets proto_err.
- Latency:
  - Accept at cycle t gives mem_req_valid at t+1.
  - After the last beat (or write handshake) at cycle u, IDLE at u+1; the next accept is possible at u+1.
- A request arriving while busy waits; it is never dropped and never reordered against its own side.
- resp_data outputs are 0 whenever the corresponding resp_valid is 0.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration: a last-grant bit updates on every accept.
  - When both sides are valid in IDLE, grant goes to the side not granted last.
  - The last-grant bit resets to icache, so dcache wins the first tie.
- Undefined: fixed dcache-over-icache priority; no last-grant state.

Test Plan:
- Icache read alone, addr=0x1000, BEATS=4, mem_req_ready=1, beats 0xA0..0xA3 contiguous -> ic_req_ready at t; mem_req_valid/addr=0x1000 at t+1; ic_resp_valid 4 cycles with data 0xA0..0xA3; dc_resp_valid 0; busy low after last beat.
- Dcache write addr=0x2000, wdata=0xDEADBEEF, wmask=0xF, mem_req_ready held 0 for 3 cycles -> req fields stable 3 cycles; dc_resp_valid pulses exactly 1 cycle after handshake with data 0; return to IDLE.
- Simultaneous ic and dc reads, held valid, fixed priority -> dcache served first, icache accepted in the cycle after dcache's 4th beat. With MEM_ARB_RR_EN and a repeated tie: grants alternate D,I,D,I.
- Reset asserted mid-RESP after 2 of 4 beats -> all outputs 0 immediately (async); after release, state IDLE and a new icache request is accepted normally.
- mem_resp_valid pulsed while IDLE -> no resp_valid to either side; proto_err=1 and stays 1 until reset.
- Dcache read with gapped beats (valid every 3rd cycle), BEATS=1 build -> single dc_resp_valid, then IDLE next cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Purpose : bundles the icache, dcache and main-memory handshake/bus signals of mem_arbiter.
// Latency : none (signal container only).
// Backpr. : n/a; 'slave' is the arbiter's view, 'master' is the surrounding system's view.
// Ports   : ic_req_* / ic_resp_* (icache), dc_req_* / dc_resp_* (dcache), mem_req_* / mem_resp_* (memory).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  ic_req_valid;
    logic                  ic_req_ready;
    logic [ADDR_W-1:0]     ic_req_addr;
    logic                  ic_resp_valid;
    logic [DATA_W-1:0]     ic_resp_data;

    logic                  dc_req_valid;
    logic                  dc_req_ready;
    logic                  dc_req_rw;
    logic [ADDR_W-1:0]     dc_req_addr;
    logic [DATA_W-1:0]     dc_req_wdata;
    logic [DATA_W/8-1:0]   dc_req_wmask;
    logic                  dc_resp_valid;
    logic [DATA_W-1:0]     dc_resp_data;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_rw;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic [DATA_W-1:0]     mem_req_wdata;
    logic [DATA_W/8-1:0]   mem_req_wmask;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_resp_data;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
        output dc_req_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
        input  dc_req_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose : shares one main-memory port between icache (reads) and dcache (reads/writes) miss traffic.
// Latency : accept at t -> mem_req_valid at t+1; read beats forwarded same cycle; write ack one cycle after handshake.
// Backpr. : one transaction at a time; both req readys are low while busy, requests wait until IDLE.
// Ports   : clk, reset (async, active-high); bus (mem_arbiter_if.slave); busy (state != IDLE);
//           proto_err (sticky, memory beat seen outside a read burst).
// Option  : define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed dcache-over-icache priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          busy,
    output logic          proto_err
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t              state_q;
    logic                own_dc_q;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                wack_q;
    logic                perr_q;

    logic                prefer_dc;
    logic                idle_ok;
    logic                gnt_dc_d;
    logic                gnt_ic_d;
    logic                beat;

`ifdef MEM_ARB_RR_EN
    // 1 when dcache took the most recent grant; icache after reset so dcache wins the first tie.
    logic last_dc_q;
    assign prefer_dc = !last_dc_q;
`else
    assign prefer_dc = 1'b1;
`endif

    // Readys are masked during reset so every output is 0 while reset is held.
    assign idle_ok  = (state_q == IDLE) && !reset;
    assign gnt_dc_d = idle_ok && bus.dc_req_valid && (prefer_dc || !bus.ic_req_valid);
    assign gnt_ic_d = idle_ok && bus.ic_req_valid && !gnt_dc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            own_dc_q <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            cnt_q    <= '0;
            wack_q   <= 1'b0;
            perr_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_dc_q <= 1'b0;
`endif
        end else begin
            wack_q <= 1'b0;
            if (bus.mem_resp_valid && state_q != RESP) begin
                perr_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (gnt_dc_d || gnt_ic_d) begin
                        own_dc_q <= gnt_dc_d;
                        rw_q     <= gnt_dc_d && bus.dc_req_rw;
                        addr_q   <= gnt_dc_d ? bus.dc_req_addr : bus.ic_req_addr;
                        wdata_q  <= gnt_dc_d ? bus.dc_req_wdata : '0;
                        wmask_q  <= (gnt_dc_d && bus.dc_req_rw) ? bus.dc_req_wmask : '0;
                        state_q  <= REQ;
`ifdef MEM_ARB_RR_EN
                        last_dc_q <= gnt_dc_d;
`endif
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        if (rw_q) begin
                            // Writes finish at the handshake; the ack is a registered pulse next cycle.
                            wack_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.mem_resp_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BEAT) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign beat = (state_q == RESP) && bus.mem_resp_valid;

    assign bus.ic_req_ready  = gnt_ic_d;
    assign bus.dc_req_ready  = gnt_dc_d;

    assign bus.ic_resp_valid = beat && !own_dc_q;
    assign bus.ic_resp_data  = (beat && !own_dc_q) ? bus.mem_resp_data : '0;
    assign bus.dc_resp_valid = wack_q || (beat && own_dc_q);
    assign bus.dc_resp_data  = (beat && own_dc_q) ? bus.mem_resp_data : '0;

    assign bus.mem_req_valid = (state_q == REQ);
    assign bus.mem_req_rw    = rw_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_wmask = wmask_q;

    assign busy      = (state_q != IDLE);
    assign proto_err = perr_q;
endmodule
